// File: rtl/bcd_gate_counter_if.sv
// rtl/bcd_gate_counter_if.sv - control/result bundle for bcd_gate_counter
interface bcd_gate_counter_if #(
  parameter int DIGITS = 4,
  parameter int GATE_W = 16
);
  logic                  start;
  logic                  abort;
  logic                  mode;
  logic [GATE_W-1:0]     gate_len;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   cnt;
  logic                  ovf;

  modport master (
    output start, abort, mode, gate_len,
    input  busy, done, cnt, ovf
  );

  modport slave (
    input  start, abort, mode, gate_len,
    output busy, done, cnt, ovf
  );
endinterface

// File: rtl/bcd_gate_counter.sv
// rtl/bcd_gate_counter.sv - period/frequency gate counter with DIGITS-digit BCD result
// Optional: define BCD_SAT_EN to saturate at all-9s instead of wrapping on overflow.
module bcd_gate_counter #(
  parameter int DIGITS = 4,
  parameter int GATE_W = 16
) (
  input  logic clk,
  input  logic clr,
  input  logic tosc,
  bcd_gate_counter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;

  state_t state, state_nxt;

  logic                sync1, sync2, prev;
  logic                tosc_rise;
  logic                mode_q;
  logic [GATE_W-1:0]   glen_q, gcnt, gcnt_inc;
  logic [4*DIGITS-1:0] acc, acc_inc, cnt_q;
  logic                acc_ovf, ovf_q;
  logic                carry, inc_wrap;
  logic                acc_en, gcnt_en, gate_end;

  assign tosc_rise = sync2 & ~prev;
  assign gcnt_inc  = gcnt + 1'b1;

  // Ripple BCD increment: a digit moves only when every lower digit is 9.
  always_comb begin
    acc_inc = acc;
    carry   = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (acc[4*k +: 4] == 4'd9) begin
          acc_inc[4*k +: 4] = 4'd0;
        end else begin
          acc_inc[4*k +: 4] = acc[4*k +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    inc_wrap = carry;
`ifdef BCD_SAT_EN
    if (carry) acc_inc = acc;
`endif
  end

  always_comb begin
    state_nxt = state;
    acc_en    = 1'b0;
    gcnt_en   = 1'b0;
    gate_end  = 1'b0;
    case (state)
      IDLE: if (bus.start) state_nxt = ARM;
      ARM: begin
        if (bus.abort)      state_nxt = IDLE;
        else if (tosc_rise) state_nxt = GATE;
      end
      GATE: begin
        if (bus.abort) begin
          state_nxt = IDLE;
        end else begin
          if (!mode_q) begin
            acc_en = 1'b1;
            if (tosc_rise) begin
              gcnt_en  = 1'b1;
              gate_end = (gcnt_inc == glen_q);
            end
          end else begin
            gcnt_en  = 1'b1;
            acc_en   = tosc_rise;
            gate_end = (gcnt_inc == glen_q);
          end
          if (gate_end) state_nxt = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      prev    <= 1'b0;
      mode_q  <= 1'b0;
      glen_q  <= '0;
      gcnt    <= '0;
      acc     <= '0;
      acc_ovf <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      sync1 <= tosc;
      sync2 <= sync1;
      prev  <= sync2;
      if (state == IDLE && bus.start) begin
        acc     <= '0;
        acc_ovf <= 1'b0;
        gcnt    <= '0;
        mode_q  <= bus.mode;
        glen_q  <= (bus.gate_len == '0) ? {{(GATE_W-1){1'b0}}, 1'b1} : bus.gate_len;
      end
      if (acc_en) begin
        acc <= acc_inc;
        if (inc_wrap) acc_ovf <= 1'b1;
      end
      if (gcnt_en) gcnt <= gcnt_inc;
      // Publish on the closing edge so cnt/ovf are already valid while done is high.
      if (gate_end) begin
        cnt_q <= acc_en ? acc_inc : acc;
        ovf_q <= acc_ovf | (acc_en & inc_wrap);
      end
    end
  end

  assign bus.busy = (state == ARM) || (state == GATE);
  assign bus.done = (state == DONE);
  assign bus.cnt  = cnt_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_bcd_gate_counter.sv
// tb/tb_bcd_gate_counter.sv - randomized self-checking bench for bcd_gate_counter
module tb_bcd_gate_counter;
  localparam int DIGITS = 4;
  localparam int GATE_W = 16;
  localparam int LIM    = 10 ** DIGITS;

  logic clk  = 1'b0;
  logic clr  = 1'b1;
  logic tosc = 1'b0;

  bcd_gate_counter_if #(.DIGITS(DIGITS), .GATE_W(GATE_W)) bus ();

  bcd_gate_counter #(.DIGITS(DIGITS), .GATE_W(GATE_W)) dut (
    .clk  (clk),
    .clr  (clr),
    .tosc (tosc),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;
  logic checking    = 1'b0;
  logic meas_active = 1'b0;
  logic [4*DIGITS-1:0] exp_cnt = '0;
  logic [4*DIGITS-1:0] pend_cnt = '0;
  logic exp_ovf  = 1'b0;
  logic pend_ovf = 1'b0;
  int   tosc_per = 8;
  logic tosc_run = 1'b0;
  int   ph = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Mode 0: gate_len periods of tosc in clk cycles. Mode 1: whole tosc periods inside the window.
  function automatic int model_val(input bit m, input int gl, input int per);
    int gle;
    gle = (gl == 0) ? 1 : gl;
    return m ? (gle / per) : (gle * per);
  endfunction

  task automatic predict(input bit m, input int gl, input int per,
                         output logic [4*DIGITS-1:0] c, output logic o);
    int v;
    v = model_val(m, gl, per);
    o = (v >= LIM);
`ifdef BCD_SAT_EN
    c = o ? to_bcd(LIM - 1) : to_bcd(v);
`else
    c = to_bcd(v % LIM);
`endif
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!tosc_run) begin
        tosc = 1'b0;
        ph   = 0;
      end else begin
        if (ph >= tosc_per) ph = 0;
        tosc = (ph < tosc_per / 2) ? 1'b1 : 1'b0;
        ph   = ph + 1;
        if (ph >= tosc_per) ph = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        if (bus.done) begin
          chk("done_expected", {31'd0, meas_active}, 32'd1);
          chk("busy_in_done", {31'd0, bus.busy}, 32'd0);
          chk("cnt_at_done", {16'd0, bus.cnt}, {16'd0, pend_cnt});
          chk("ovf_at_done", {31'd0, bus.ovf}, {31'd0, pend_ovf});
          exp_cnt     = pend_cnt;
          exp_ovf     = pend_ovf;
          meas_active = 1'b0;
          done_seen++;
        end else begin
          chk("busy", {31'd0, bus.busy}, {31'd0, meas_active});
          chk("cnt_hold", {16'd0, bus.cnt}, {16'd0, exp_cnt});
          chk("ovf_hold", {31'd0, bus.ovf}, {31'd0, exp_ovf});
        end
      end
    end
  end

  task automatic do_start(input bit m, input int gl);
    @(negedge clk);
    bus.mode     = m;
    bus.gate_len = GATE_W'(gl);
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    meas_active = 1'b1;
  endtask

  task automatic do_abort();
    @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort   = 1'b0;
    meas_active = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (meas_active && i < budget) begin
      @(negedge clk);
      i++;
    end
    #1;
    chk("done_within_budget", {31'd0, meas_active}, 32'd0);
    if (meas_active) do_abort();
  endtask

  task automatic set_tosc(input int per, input bit run);
    tosc_per = per;
    tosc_run = run;
    repeat (64) @(negedge clk);
  endtask

  task automatic run(input bit m, input int gl, input int per);
    int gle;
    gle = (gl == 0) ? 1 : gl;
    set_tosc(per, 1'b1);
    predict(m, gl, per, pend_cnt, pend_ovf);
    do_start(m, gl);
    wait_done(m ? (gle + 4 * per + 100) : (2 * gle * per + 4 * per + 100));
  endtask

  initial begin
    int d0;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.mode     = 1'b0;
    bus.gate_len = '0;

    chk("model_pin_period", {16'd0, to_bcd(model_val(1'b0, 10, 8))}, 32'h0080);
    chk("model_pin_freq", {16'd0, to_bcd(model_val(1'b1, 100, 4))}, 32'h0025);
    chk("model_pin_gl0", model_val(1'b0, 0, 5), 32'd5);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cnt", {16'd0, bus.cnt}, 32'd0);
    chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    clr = 1'b0;
    checking = 1'b1;

    d0 = done_seen;
    run(1'b0, 10, 8);
    chk("t1_cnt", {16'd0, bus.cnt}, 32'h0080);
    chk("t1_ovf", {31'd0, bus.ovf}, 32'd0);
    chk("t1_one_done", done_seen - d0, 32'd1);
    @(negedge clk);
    chk("t1_busy_after", {31'd0, bus.busy}, 32'd0);

    run(1'b1, 100, 4);
    chk("t2_cnt", {16'd0, bus.cnt}, 32'h0025);
    chk("t2_ovf", {31'd0, bus.ovf}, 32'd0);

    run(1'b0, 2000, 8);
`ifdef BCD_SAT_EN
    chk("t3_cnt", {16'd0, bus.cnt}, 32'h9999);
`else
    chk("t3_cnt", {16'd0, bus.cnt}, 32'h6000);
`endif
    chk("t3_ovf", {31'd0, bus.ovf}, 32'd1);

    run(1'b0, 10, 8);
    chk("t4_cnt", {16'd0, bus.cnt}, 32'h0080);
    do_start(1'b0, 10);
    repeat (40) @(negedge clk);
    do_abort();
    @(negedge clk);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_cnt", {16'd0, bus.cnt}, 32'h0080);

    set_tosc(8, 1'b1);
    predict(1'b0, 10, 8, pend_cnt, pend_ovf);
    d0 = done_seen;
    do_start(1'b0, 10);
    repeat (20) @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(400);
    repeat (100) @(negedge clk);
    chk("busy_start_single_done", done_seen - d0, 32'd1);

    do_start(1'b0, 10);
    repeat (40) @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr         = 1'b0;
    meas_active = 1'b0;
    exp_cnt     = '0;
    exp_ovf     = 1'b0;
    @(negedge clk);
    chk("clr_cnt", {16'd0, bus.cnt}, 32'd0);
    chk("clr_ovf", {31'd0, bus.ovf}, 32'd0);
    chk("clr_busy", {31'd0, bus.busy}, 32'd0);
    chk("clr_done", {31'd0, bus.done}, 32'd0);
    run(1'b0, 0, 5);
    chk("gl0_cnt", {16'd0, bus.cnt}, 32'h0005);

    set_tosc(8, 1'b0);
    d0 = done_seen;
    do_start(1'b0, 10);
    repeat (1000) @(negedge clk);
    chk("stall_busy", {31'd0, bus.busy}, 32'd1);
    chk("stall_no_done", done_seen - d0, 32'd0);
    do_abort();
    @(negedge clk);
    chk("stall_abort_busy", {31'd0, bus.busy}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      bit m;
      int per, gl;
      m   = 1'($urandom_range(0, 1));
      per = int'($urandom_range(2, 12));
      gl  = m ? int'($urandom_range(0, 300)) : int'($urandom_range(0, 200));
      run(m, gl, per);
    end

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
